// File: rtl/host_run_ctrl_pkg.sv
// Shared definitions for host_run_ctrl: state encoding and parameter defaults.
// RUN_TIMEOUT_EN selects whether the run-cycle limit is enforced.
package Definitions;

    localparam int DEF_DATA_PATH_WIDTH = 8;
    localparam int DEF_ADDR_WIDTH      = 8;
    localparam int DEF_RST_CYCLES      = 2;
    localparam int DEF_CNT_WIDTH       = 32;
    localparam int DEF_TIMEOUT_CYCLES  = 100000;

`ifdef RUN_TIMEOUT_EN
    localparam bit TIMEOUT_EN = 1'b1;
`else
    localparam bit TIMEOUT_EN = 1'b0;
`endif

    typedef enum logic [2:0] {
        IDLE,
        RST,
        START,
        RUN,
        DUMP,
        FIN,
        TOUT
    } host_state_t;

endpackage

// File: rtl/host_run_ctrl_if.sv
// Dump stream between host_run_ctrl (master) and the host-side consumer (slave).
interface host_run_ctrl_if #(
    parameter int DATA_PATH_WIDTH = Definitions::DEF_DATA_PATH_WIDTH,
    parameter int ADDR_WIDTH      = Definitions::DEF_ADDR_WIDTH
) ();

    logic                       out_valid;
    logic                       out_ready;
    logic [DATA_PATH_WIDTH-1:0] out_data;
    logic [ADDR_WIDTH-1:0]      out_addr;

    modport master (
        output out_valid,
        output out_data,
        output out_addr,
        input  out_ready
    );

    modport slave (
        input  out_valid,
        input  out_data,
        input  out_addr,
        output out_ready
    );

endinterface

// File: rtl/host_run_ctrl_run_timer.sv
// Saturating core run-length counter with the run-limit compare.
// The compare only asserts when RUN_TIMEOUT_EN is defined (see Definitions).
module run_timer
    import Definitions::*;
#(
    parameter int CNT_WIDTH      = DEF_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES = DEF_TIMEOUT_CYCLES
) (
    input  logic                 clk,
    input  logic                 reset_n,
    input  logic                 clear,
    input  logic                 enable,
    output logic [CNT_WIDTH-1:0] count,
    output logic                 limit_hit
);

    localparam logic [CNT_WIDTH-1:0] ONE   = CNT_WIDTH'(1);
    localparam logic [CNT_WIDTH-1:0] LIMIT = CNT_WIDTH'(TIMEOUT_CYCLES - 1);

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            count <= '0;
        end else if (clear) begin
            count <= '0;
        end else if (enable && (count != '1)) begin
            count <= count + ONE;
        end
    end

    // Fires during the run cycle that brings the count up to the limit.
    assign limit_hit = TIMEOUT_EN && (count >= LIMIT);

endmodule

// File: rtl/host_run_ctrl.sv
// Host-side run controller: resets and starts the core, times the run, then dumps a
// window of data memory over the stream. Optional run limit via RUN_TIMEOUT_EN.
module host_run_ctrl
    import Definitions::*;
#(
    parameter int DATA_PATH_WIDTH = DEF_DATA_PATH_WIDTH,
    parameter int ADDR_WIDTH      = DEF_ADDR_WIDTH,
    parameter int RST_CYCLES      = DEF_RST_CYCLES,
    parameter int CNT_WIDTH       = DEF_CNT_WIDTH,
    parameter int TIMEOUT_CYCLES  = DEF_TIMEOUT_CYCLES
) (
    input  logic                       clk,
    input  logic                       reset_n,
    input  logic                       go,
    input  logic [ADDR_WIDTH-1:0]      dump_base,
    input  logic [ADDR_WIDTH:0]        dump_len,
    output logic                       core_reset,
    output logic                       core_start,
    input  logic                       core_done,
    output logic [ADDR_WIDTH-1:0]      mem_raddr,
    input  logic [DATA_PATH_WIDTH-1:0] mem_rdata,
    host_run_ctrl_if.master            dump,
    output logic                       busy,
    output logic                       finished,
    output logic                       timeout,
    output logic [CNT_WIDTH-1:0]       cycle_count
);

    localparam int RW = (RST_CYCLES > 1) ? $clog2(RST_CYCLES) : 1;
    localparam logic [RW-1:0]         RST_LAST = RW'(RST_CYCLES - 1);
    localparam logic [RW-1:0]         RST_ONE  = RW'(1);
    localparam logic [ADDR_WIDTH-1:0] PTR_ONE  = ADDR_WIDTH'(1);
    localparam logic [ADDR_WIDTH:0]   LEN_ONE  = (ADDR_WIDTH + 1)'(1);

    host_state_t           state_q;
    host_state_t           state_d;
    logic [RW-1:0]         rst_cnt;
    logic [ADDR_WIDTH-1:0] base_q;
    logic [ADDR_WIDTH-1:0] ptr;
    logic [ADDR_WIDTH:0]   remaining;
    logic                  accept_go;
    logic                  timer_hit;

    assign accept_go = go && ((state_q == IDLE) || (state_q == FIN) || (state_q == TOUT));

    run_timer #(
        .CNT_WIDTH      (CNT_WIDTH),
        .TIMEOUT_CYCLES (TIMEOUT_CYCLES)
    ) u_run_timer (
        .clk       (clk),
        .reset_n   (reset_n),
        .clear     (state_q == START),
        .enable    (state_q == RUN),
        .count     (cycle_count),
        .limit_hit (timer_hit)
    );

    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            state_q <= IDLE;
        end else begin
            state_q <= state_d;
        end
    end

    always_comb begin
        state_d    = state_q;
        core_reset = 1'b0;
        core_start = 1'b0;
        busy       = 1'b0;
        finished   = 1'b0;
        dump.out_valid = 1'b0;
        mem_raddr  = base_q;
        case (state_q)
            IDLE, FIN, TOUT: begin
                core_reset = (state_q != FIN);
                finished   = (state_q == FIN);
                if (go) state_d = RST;
            end
            RST: begin
                core_reset = 1'b1;
                busy       = 1'b1;
                if (rst_cnt == RST_LAST) state_d = START;
            end
            START: begin
                core_start = 1'b1;
                busy       = 1'b1;
                state_d    = RUN;
            end
            RUN: begin
                busy = 1'b1;
                // A halt seen in the same cycle as the limit counts as a normal finish.
                if (core_done) begin
                    state_d = (remaining == '0) ? FIN : DUMP;
                end else if (timer_hit) begin
                    state_d = TOUT;
                end
            end
            DUMP: begin
                busy           = 1'b1;
                dump.out_valid = 1'b1;
                mem_raddr      = ptr;
                if (dump.out_ready && (remaining == LEN_ONE)) state_d = FIN;
            end
            default: state_d = IDLE;
        endcase
    end

    // Latched request, reset-hold counter and dump pointer/remaining count.
    always_ff @(posedge clk or negedge reset_n) begin
        if (!reset_n) begin
            rst_cnt   <= '0;
            base_q    <= '0;
            ptr       <= '0;
            remaining <= '0;
        end else if (accept_go) begin
            rst_cnt   <= '0;
            base_q    <= dump_base;
            ptr       <= dump_base;
            remaining <= dump_len;
        end else if (state_q == RST) begin
            rst_cnt <= rst_cnt + RST_ONE;
        end else if ((state_q == DUMP) && dump.out_ready) begin
            ptr       <= ptr + PTR_ONE;
            remaining <= remaining - LEN_ONE;
        end
    end

    assign dump.out_addr = ptr;
    assign dump.out_data = mem_rdata;

`ifdef RUN_TIMEOUT_EN
    assign timeout = (state_q == TOUT);
`else
    assign timeout = 1'b0;
`endif

endmodule

// File: tb/tb_host_run_ctrl.sv
// Randomized self-checking bench for host_run_ctrl against a queue-based run/dump model.
// Exercises the run limit when RUN_TIMEOUT_EN is defined.
module tb_host_run_ctrl;
    import Definitions::*;

    localparam int DW   = 8;
    localparam int AW   = 8;
    localparam int RSTC = 2;
    localparam int CW   = 32;
    localparam int TMO  = 50;

    logic          clk = 1'b0;
    logic          reset_n = 1'b0;
    logic          go = 1'b0;
    logic          core_done = 1'b0;
    logic [AW-1:0] dump_base = '0;
    logic [AW:0]   dump_len = '0;
    logic          core_reset, core_start, busy, finished, timeout;
    logic [AW-1:0] mem_raddr;
    logic [DW-1:0] mem_rdata;
    logic [CW-1:0] cycle_count;
    logic [DW-1:0] mem [256];

    int total = 0;
    int bad   = 0;

    host_run_ctrl_if #(.DATA_PATH_WIDTH(DW), .ADDR_WIDTH(AW)) dump_if ();

    host_run_ctrl #(
        .DATA_PATH_WIDTH (DW),
        .ADDR_WIDTH      (AW),
        .RST_CYCLES      (RSTC),
        .CNT_WIDTH       (CW),
        .TIMEOUT_CYCLES  (TMO)
    ) dut (
        .clk         (clk),
        .reset_n     (reset_n),
        .go          (go),
        .dump_base   (dump_base),
        .dump_len    (dump_len),
        .core_reset  (core_reset),
        .core_start  (core_start),
        .core_done   (core_done),
        .mem_raddr   (mem_raddr),
        .mem_rdata   (mem_rdata),
        .dump        (dump_if),
        .busy        (busy),
        .finished    (finished),
        .timeout     (timeout),
        .cycle_count (cycle_count)
    );

    always #5 clk = ~clk;

    assign mem_rdata = mem[mem_raddr];

    task automatic test_reset;
        reset_n = 1'b0;
        dump_if.out_ready = 1'b0;
        #1;
        total++;
        if ({core_reset, core_start, dump_if.out_valid, busy, finished, timeout} !== 6'b100000) begin
            bad++;
            $display("[TB] FAIL reset_flags: got %b want 100000",
                     {core_reset, core_start, dump_if.out_valid, busy, finished, timeout});
        end
        total++;
        if (cycle_count !== '0 || mem_raddr !== '0) begin
            bad++;
            $display("[TB] FAIL reset_regs: got count=%0d raddr=%0h want 0/0", cycle_count, mem_raddr);
        end
        @(negedge clk);
        reset_n = 1'b1;
        repeat (3) @(negedge clk);
        total++;
        if (core_reset !== 1'b1 || busy !== 1'b0) begin
            bad++;
            $display("[TB] FAIL idle_hold: got core_reset=%b busy=%b want 1/0", core_reset, busy);
        end
    endtask

    // One full job: go, reset hold, start, run of `delay` cycles (or never done if < 0),
    // then the dump compared against base+i (mod 256) and the model memory.
    task automatic run_job(input string name, input logic [AW-1:0] base, input logic [AW:0] len,
                           input int delay, input int mode, input bit expect_tout, input bit glitch_go);
        logic [AW-1:0] exp_addr [$];
        logic [AW-1:0] held_addr = '0;
        logic [DW-1:0] held_data = '0;
        int  rst_cycles = 0, start_cycles = 0, valid_cycles = 0, words = 0, since_start = -1;
        bit  pend = 1'b0, ended = 1'b0, saw_tout = 1'b0, r;
        int  exp_count;
        for (int i = 0; i < int'(len); i++) exp_addr.push_back(AW'(int'(base) + i));
        exp_count = expect_tout ? TMO : delay;

        @(negedge clk);
        core_done = 1'b0;
        dump_base = base;
        dump_len  = len;
        go        = 1'b1;
        @(negedge clk);
        go        = 1'b0;
        dump_base = AW'($urandom);
        dump_len  = (AW + 1)'($urandom);

        for (int cyc = 0; cyc < 2000 && !ended; cyc++) begin
            if (since_start >= 0) since_start++;
            if (core_start) begin
                start_cycles++;
                since_start = 0;
            end
            if (core_reset && busy) rst_cycles++;
            if (delay >= 0 && since_start >= delay) core_done = 1'b1;
            if (glitch_go && since_start == 5) begin
                go        = 1'b1;
                dump_base = base ^ 8'h5A;
                dump_len  = 1;
            end else begin
                go = 1'b0;
            end
            case (mode)
                0:       r = 1'b1;
                1:       r = cyc[0];
                default: r = 1'($urandom_range(0, 1));
            endcase
            dump_if.out_ready = r;
            #1;
            if (dump_if.out_valid) begin
                valid_cycles++;
                if (pend) begin
                    total++;
                    if (dump_if.out_addr !== held_addr || dump_if.out_data !== held_data) begin
                        bad++;
                        $display("[TB] FAIL %s stall_stable: got %0h/%0h want %0h/%0h", name,
                                 dump_if.out_addr, dump_if.out_data, held_addr, held_data);
                    end
                end
                total++;
                if (words >= exp_addr.size()) begin
                    bad++;
                    $display("[TB] FAIL %s extra_word: got word %0d want only %0d", name, words, exp_addr.size());
                end else if (dump_if.out_addr !== exp_addr[words] || mem_raddr !== exp_addr[words] ||
                             dump_if.out_data !== mem[exp_addr[words]]) begin
                    bad++;
                    $display("[TB] FAIL %s word%0d: got addr=%0h raddr=%0h data=%0h want addr=%0h data=%0h",
                             name, words, dump_if.out_addr, mem_raddr, dump_if.out_data,
                             exp_addr[words], mem[exp_addr[words]]);
                end
                if (r) begin
                    words++;
                    pend = 1'b0;
                end else begin
                    pend      = 1'b1;
                    held_addr = dump_if.out_addr;
                    held_data = dump_if.out_data;
                end
            end else if (pend) begin
                total++;
                bad++;
                $display("[TB] FAIL %s valid_dropped: got out_valid=0 want 1", name);
                pend = 1'b0;
            end
            if (timeout) saw_tout = 1'b1;
            if (finished || timeout) ended = 1'b1;
            @(negedge clk);
        end
        #1;

        total++;
        if (!ended) begin
            bad++;
            $display("[TB] FAIL %s job_timeout: got no finish want finished/timeout", name);
        end
        total++;
        if (rst_cycles != RSTC || start_cycles != 1) begin
            bad++;
            $display("[TB] FAIL %s rst_start: got rst=%0d start=%0d want %0d/1", name, rst_cycles, start_cycles, RSTC);
        end
        total++;
        if (words != (expect_tout ? 0 : int'(len))) begin
            bad++;
            $display("[TB] FAIL %s word_count: got %0d want %0d", name, words, expect_tout ? 0 : int'(len));
        end
        if (mode == 0 || len == 0) begin
            total++;
            if (valid_cycles != (expect_tout ? 0 : int'(len))) begin
                bad++;
                $display("[TB] FAIL %s valid_cycles: got %0d want %0d", name, valid_cycles, len);
            end
        end
        total++;
        if (cycle_count !== CW'(exp_count)) begin
            bad++;
            $display("[TB] FAIL %s cycle_count: got %0d want %0d", name, cycle_count, exp_count);
        end
        total++;
        if ({finished, timeout, saw_tout, core_reset, busy, core_start, dump_if.out_valid} !==
            {!expect_tout, expect_tout, expect_tout, expect_tout, 3'b000}) begin
            bad++;
            $display("[TB] FAIL %s end_flags: got %b want %b", name,
                     {finished, timeout, saw_tout, core_reset, busy, core_start, dump_if.out_valid},
                     {!expect_tout, expect_tout, expect_tout, expect_tout, 3'b000});
        end
        total++;
        if (mem_raddr !== base) begin
            bad++;
            $display("[TB] FAIL %s raddr_latched: got %0h want %0h", name, mem_raddr, base);
        end
    endtask

    task automatic test_basic;
        run_job("basic", 8'h10, 9'd4, 20, 0, 1'b0, 1'b0);
    endtask

    task automatic test_wrap;
        run_job("wrap", 8'hFE, 9'd3, 7, 0, 1'b0, 1'b0);
        run_job("full", AW'($urandom), 9'd256, 3, 2, 1'b0, 1'b0);
    endtask

    task automatic test_backpressure;
        run_job("toggle", 8'h30, 9'd8, 12, 1, 1'b0, 1'b0);
    endtask

    task automatic test_zero_len;
        run_job("zero_len", 8'h22, 9'd0, 9, 0, 1'b0, 1'b0);
    endtask

    task automatic test_go_ignored;
        run_job("go_in_run", 8'h80, 9'd5, 15, 2, 1'b0, 1'b1);
    endtask

    task automatic test_random;
        for (int k = 0; k < 6; k++) begin
            run_job("random", AW'($urandom), (AW + 1)'($urandom_range(0, 24)),
                    int'($urandom_range(1, 40)), int'($urandom_range(0, 2)), 1'b0, 1'b0);
        end
    endtask

`ifdef RUN_TIMEOUT_EN
    task automatic test_timeout;
        run_job("timeout", 8'h05, 9'd6, -1, 0, 1'b1, 1'b0);
        run_job("restart", 8'h60, 9'd3, 10, 0, 1'b0, 1'b0);
        run_job("done_at_limit", 8'h70, 9'd2, TMO, 0, 1'b0, 1'b0);
    endtask
`else
    task automatic test_timeout;
        run_job("no_limit", 8'h05, 9'd2, 2 * TMO, 0, 1'b0, 1'b0);
    endtask
`endif

    task automatic test_reset_mid_dump;
        int guard = 0;
        @(negedge clk);
        core_done = 1'b0;
        dump_base = 8'h40;
        dump_len  = 9'd10;
        dump_if.out_ready = 1'b1;
        go = 1'b1;
        @(negedge clk);
        go = 1'b0;
        repeat (8) @(negedge clk);
        core_done = 1'b1;
        while (!dump_if.out_valid && guard < 50) begin
            @(negedge clk);
            guard++;
        end
        @(negedge clk);
        total++;
        if (dump_if.out_valid !== 1'b1 || busy !== 1'b1) begin
            bad++;
            $display("[TB] FAIL mid_dump_entry: got valid=%b busy=%b want 1/1", dump_if.out_valid, busy);
        end
        #2;
        reset_n = 1'b0;
        #1;
        total++;
        if ({core_reset, core_start, dump_if.out_valid, busy, finished, timeout} !== 6'b100000 ||
            cycle_count !== '0 || mem_raddr !== '0) begin
            bad++;
            $display("[TB] FAIL async_reset: got flags=%b count=%0d raddr=%0h want 100000/0/0",
                     {core_reset, core_start, dump_if.out_valid, busy, finished, timeout}, cycle_count, mem_raddr);
        end
        @(negedge clk);
        reset_n   = 1'b1;
        core_done = 1'b0;
        repeat (2) @(negedge clk);
        total++;
        if (core_reset !== 1'b1 || busy !== 1'b0 || dump_if.out_valid !== 1'b0) begin
            bad++;
            $display("[TB] FAIL post_reset_idle: got core_reset=%b busy=%b valid=%b want 1/0/0",
                     core_reset, busy, dump_if.out_valid);
        end
    endtask

    initial begin
        for (int a = 0; a < 256; a++) mem[a] = DW'($urandom);
        test_reset();
        test_basic();
        test_wrap();
        test_backpressure();
        test_zero_len();
        test_go_ignored();
        test_random();
        test_timeout();
        test_reset_mid_dump();
        run_job("after_reset", 8'hF0, 9'd20, 5, 2, 1'b0, 1'b0);
        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
